panda_div_gen: RTL and testbench

- Parametrised successor to the single-channel pulse divider.
- Routes qualifying input edges to outd_o, the divided output, once every DIVISOR edges. All other edges go to outn_o.
- Adds configurable counter width, selectable edge qualification (rising, falling or both), a gating enable, defined DIVISOR 0/1 handling, and automatic reload on register change.
- Sits in the soft-block fabric between the bit bus inputs and outputs; registers are written from the register interface.

---
 rtl/panda_div_pkg.sv | 13 +
 rtl/panda_edge_det.sv | 43 ++++
 rtl/panda_div_gen.sv | 113 +++++++++++
 tb/tb_panda_div_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/panda_div_pkg.sv
// panda_div_pkg: shared definitions for the panda soft-block pulse dividers.
//   edge_mode_t : 2-bit edge qualification selector (rising, falling, both;
//                 code 3 is an alias for rising).
package panda_div_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE     = 2'd0,
        EDGE_FALL     = 2'd1,
        EDGE_BOTH     = 2'd2,
        EDGE_RISE_ALT = 2'd3
    } edge_mode_t;

endpackage

// File: rtl/panda_edge_det.sv
// panda_edge_det: registers a copy of a bit-bus input and flags the
// transitions selected by edge_mode. It can be reused by other soft blocks.
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   inp       in   input bit being watched
//   edge_mode in   2-bit edge selection (see panda_div_pkg::edge_mode_t)
//   edge_hit  out  combinational: a qualifying transition is present this cycle
module panda_edge_det
    import panda_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inp,
    input  logic [1:0] edge_mode,
    output logic       edge_hit
);

    logic inp_d;
    logic rise;
    logic fall;

    // The copy follows inp every cycle, including while the owner ignores
    // edges, so re-enabling never produces a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inp_d <= 1'b0;
        end else begin
            inp_d <= inp;
        end
    end

    always_comb begin
        rise     = inp & ~inp_d;
        fall     = ~inp & inp_d;
        edge_hit = rise;
        case (edge_mode_t'(edge_mode))
            EDGE_FALL: edge_hit = fall;
            EDGE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = rise;
        endcase
    end

endmodule

// File: rtl/panda_div_gen.sv
// panda_div_gen: pulse divider. Every DIVISOR-th qualifying edge of inp_i
// produces a one-cycle pulse on outd_o; all other qualifying edges pulse outn_o.
//   clk_i       in   system clock
//   reset_i     in   asynchronous active-high reset
//   inp_i       in   pulse input from the bit bus
//   ena_i       in   enable; edges are ignored while low
//   rst_i       in   synchronous counter reset from the bit bus
//   DIVISOR     in   divide ratio (0 behaves as 1)
//   FIRST_PULSE in   0: first edge goes to outn_o, 1: first edge goes to outd_o
//   EDGE_MODE   in   0 rising, 1 falling, 2 both, 3 rising
//   FORCE_RST   in   one-cycle register strobe, same effect as rst_i
//   outd_o      out  divided pulse
//   outn_o      out  non-divided pulse
//   COUNT       out  current counter value
module panda_div_gen
    import panda_div_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   inp_i,
    input  logic                   ena_i,
    input  logic                   rst_i,
    input  logic [COUNT_WIDTH-1:0] DIVISOR,
    input  logic                   FIRST_PULSE,
    input  logic [1:0]             EDGE_MODE,
    input  logic                   FORCE_RST,
    output logic                   outd_o,
    output logic                   outn_o,
    output logic [COUNT_WIDTH-1:0] COUNT
);

    logic                   edge_hit;
    logic                   reload;
    logic                   reload_pend;
    logic [COUNT_WIDTH-1:0] div_q;
    logic                   first_q;
    logic [1:0]             mode_q;

    logic [COUNT_WIDTH-1:0] div_eff;
    logic [COUNT_WIDTH-1:0] div_last;
    logic [COUNT_WIDTH-1:0] init_val;

    logic [COUNT_WIDTH-1:0] count_nxt;
    logic                   outd_nxt;
    logic                   outn_nxt;
    logic                   pend_nxt;

    panda_edge_det u_edge_det (
        .clk       (clk_i),
        .rst       (reset_i),
        .inp       (inp_i),
        .edge_mode (EDGE_MODE),
        .edge_hit  (edge_hit)
    );

    always_comb begin
        div_eff  = (DIVISOR == '0) ? COUNT_WIDTH'(1) : DIVISOR;
        // div_eff is at least 1, so this never underflows.
        div_last = div_eff - COUNT_WIDTH'(1);
        init_val = FIRST_PULSE ? div_last : '0;

        // Any register change restarts the count from INIT, so software
        // never has to pair a configuration write with FORCE_RST.
        reload = rst_i | FORCE_RST | reload_pend
               | (DIVISOR != div_q)
               | (FIRST_PULSE != first_q)
               | (EDGE_MODE != mode_q);

        count_nxt = COUNT;
        outd_nxt  = 1'b0;
        outn_nxt  = 1'b0;
        pend_nxt  = reload_pend;

        if (reload) begin
            // An edge coincident with a reload is dropped.
            count_nxt = init_val;
            pend_nxt  = 1'b0;
        end else if (edge_hit && ena_i) begin
            // >= rather than == so a shrunken divisor cannot let COUNT run
            // past the new terminal value.
            if (COUNT >= div_last) begin
                count_nxt = '0;
                outd_nxt  = 1'b1;
            end else begin
                count_nxt = COUNT + COUNT_WIDTH'(1);
                outn_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            COUNT       <= '0;
            outd_o      <= 1'b0;
            outn_o      <= 1'b0;
            reload_pend <= 1'b1;
            div_q       <= '0;
            first_q     <= 1'b0;
            mode_q      <= 2'd0;
        end else begin
            COUNT       <= count_nxt;
            outd_o      <= outd_nxt;
            outn_o      <= outn_nxt;
            reload_pend <= pend_nxt;
            div_q       <= DIVISOR;
            first_q     <= FIRST_PULSE;
            mode_q      <= EDGE_MODE;
        end
    end

endmodule

// File: tb/tb_panda_div_gen.sv
// tb_panda_div_gen: directed self-checking bench for panda_div_gen.
module tb_panda_div_gen;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          inp_i;
    logic          ena_i;
    logic          rst_i;
    logic [CW-1:0] DIVISOR;
    logic          FIRST_PULSE;
    logic [1:0]    EDGE_MODE;
    logic          FORCE_RST;
    logic          outd_o;
    logic          outn_o;
    logic [CW-1:0] COUNT;

    int checks   = 0;
    int failures = 0;
    int outd_seen;

    panda_div_gen #(.COUNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .inp_i       (inp_i),
        .ena_i       (ena_i),
        .rst_i       (rst_i),
        .DIVISOR     (DIVISOR),
        .FIRST_PULSE (FIRST_PULSE),
        .EDGE_MODE   (EDGE_MODE),
        .FORCE_RST   (FORCE_RST),
        .outd_o      (outd_o),
        .outn_o      (outn_o),
        .COUNT       (COUNT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic ed, input logic en,
                         input logic [CW-1:0] ec);
        checks++;
        assert (outd_o === ed) else begin
            failures++;
            $error("FAIL %s outd_o observed=%b expected=%b", tag, outd_o, ed);
        end
        checks++;
        assert (outn_o === en) else begin
            failures++;
            $error("FAIL %s outn_o observed=%b expected=%b", tag, outn_o, en);
        end
        checks++;
        assert (COUNT === ec) else begin
            failures++;
            $error("FAIL %s COUNT observed=%0d expected=%0d", tag, COUNT, ec);
        end
    endtask

    // Drive inp_i to v, advance one clock, check the result.
    task automatic drive(input string tag, input logic v, input logic ed,
                         input logic en, input logic [CW-1:0] ec);
        inp_i = v;
        @(negedge clk);
        check(tag, ed, en, ec);
    endtask

    // One rising edge then back low (rising-edge mode).
    task automatic pulse(input string tag, input logic ed, input logic en,
                         input logic [CW-1:0] ec);
        drive(tag, 1'b1, ed, en, ec);
        drive({tag, "_low"}, 1'b0, 1'b0, 1'b0, ec);
    endtask

    initial begin
        reset_i     = 1'b1;
        inp_i       = 1'b0;
        ena_i       = 1'b1;
        rst_i       = 1'b0;
        FORCE_RST   = 1'b0;
        DIVISOR     = 8'd3;
        FIRST_PULSE = 1'b0;
        EDGE_MODE   = 2'd0;
        @(negedge clk);
        check("reset", 1'b0, 1'b0, 8'd0);
        reset_i = 1'b0;
        @(negedge clk);
        check("post_reset_reload", 1'b0, 1'b0, 8'd0);

        // 1: divide by 3, rising edges
        pulse("t1_e1", 1'b0, 1'b1, 8'd1);
        pulse("t1_e2", 1'b0, 1'b1, 8'd2);
        pulse("t1_e3", 1'b1, 1'b0, 8'd0);
        pulse("t1_e4", 1'b0, 1'b1, 8'd1);
        pulse("t1_e5", 1'b0, 1'b1, 8'd2);
        pulse("t1_e6", 1'b1, 1'b0, 8'd0);

        // 2: divide by 4, first pulse to outd
        DIVISOR     = 8'd4;
        FIRST_PULSE = 1'b1;
        @(negedge clk);
        check("t2_reload", 1'b0, 1'b0, 8'd3);
        pulse("t2_e1", 1'b1, 1'b0, 8'd0);
        pulse("t2_e2", 1'b0, 1'b1, 8'd1);
        pulse("t2_e3", 1'b0, 1'b1, 8'd2);
        pulse("t2_e4", 1'b0, 1'b1, 8'd3);
        pulse("t2_e5", 1'b1, 1'b0, 8'd0);

        // 3: both edges, divide by 2, pulses 4 cycles wide
        EDGE_MODE   = 2'd2;
        DIVISOR     = 8'd2;
        FIRST_PULSE = 1'b0;
        @(negedge clk);
        check("t3_reload", 1'b0, 1'b0, 8'd0);
        outd_seen = 0;
        for (int p = 0; p < 3; p++) begin
            drive("t3_rise", 1'b1, 1'b0, 1'b1, 8'd1);
            for (int k = 0; k < 3; k++) drive("t3_high", 1'b1, 1'b0, 1'b0, 8'd1);
            drive("t3_fall", 1'b0, 1'b1, 1'b0, 8'd0);
            if (outd_o === 1'b1) outd_seen++;
            for (int k = 0; k < 3; k++) drive("t3_low", 1'b0, 1'b0, 1'b0, 8'd0);
        end
        checks++;
        assert (outd_seen === 3) else begin
            failures++;
            $error("FAIL t3_outd_total observed=%0d expected=3", outd_seen);
        end

        // 4: rst_i coincident with a rising edge at COUNT = 2
        EDGE_MODE = 2'd0;
        DIVISOR   = 8'd3;
        @(negedge clk);
        check("t4_reload", 1'b0, 1'b0, 8'd0);
        pulse("t4_e1", 1'b0, 1'b1, 8'd1);
        pulse("t4_e2", 1'b0, 1'b1, 8'd2);
        rst_i = 1'b1;
        drive("t4_rst_edge", 1'b1, 1'b0, 1'b0, 8'd0);
        rst_i = 1'b0;
        drive("t4_after", 1'b0, 1'b0, 1'b0, 8'd0);
        pulse("t4_next", 1'b0, 1'b1, 8'd1);

        // 5: DIVISOR 0 then 1 -> every edge on outd
        DIVISOR = 8'd0;
        @(negedge clk);
        check("t5_reload0", 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) pulse("t5_div0", 1'b1, 1'b0, 8'd0);
        DIVISOR = 8'd1;
        @(negedge clk);
        check("t5_reload1", 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) pulse("t5_div1", 1'b1, 1'b0, 8'd0);

        // falling-edge mode
        EDGE_MODE = 2'd1;
        DIVISOR   = 8'd3;
        @(negedge clk);
        check("fall_reload", 1'b0, 1'b0, 8'd0);
        drive("fall_rise_ignored", 1'b1, 1'b0, 1'b0, 8'd0);
        drive("fall_counted", 1'b0, 1'b0, 1'b1, 8'd1);

        // 6: enable gating, then divisor shrink mid-count
        EDGE_MODE = 2'd0;
        DIVISOR   = 8'd5;
        @(negedge clk);
        check("t6_reload", 1'b0, 1'b0, 8'd0);
        pulse("t6_e1", 1'b0, 1'b1, 8'd1);
        ena_i = 1'b0;
        pulse("t6_dis1", 1'b0, 1'b0, 8'd1);
        pulse("t6_dis2", 1'b0, 1'b0, 8'd1);
        ena_i = 1'b1;
        drive("t6_reenable", 1'b0, 1'b0, 1'b0, 8'd1);
        pulse("t6_e2", 1'b0, 1'b1, 8'd2);
        DIVISOR = 8'd3;
        @(negedge clk);
        check("t6_div_write", 1'b0, 1'b0, 8'd0);
        pulse("t6_e3", 1'b0, 1'b1, 8'd1);

        // FORCE_RST strobe
        FORCE_RST = 1'b1;
        @(negedge clk);
        FORCE_RST = 1'b0;
        check("force_rst", 1'b0, 1'b0, 8'd0);
        pulse("force_next", 1'b0, 1'b1, 8'd1);

        // reset_i while a pulse is high: outputs drop immediately
        inp_i = 1'b1;
        @(posedge clk);
        #2;
        check("async_pre", 1'b0, 1'b1, 8'd2);
        reset_i = 1'b1;
        #1;
        check("async_reset", 1'b0, 1'b0, 8'd0);
        inp_i = 1'b0;
        @(negedge clk);
        reset_i     = 1'b0;
        FIRST_PULSE = 1'b1;
        @(negedge clk);
        check("async_release_reload", 1'b0, 1'b0, 8'd2);
        pulse("async_next", 1'b1, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
